// File: rtl/pc_btb.sv
// -----------------------------------------------------------------------------
// pc_btb -- fetch-stage program counter with a direct-mapped branch target
// buffer and one 2-bit saturating direction counter per entry.
//
// Every cycle the current pc is looked up combinationally. A tag hit with a
// counter in a "taken" state (ctr[1] = 1) predicts the stored target.
// Otherwise the prediction is pc+4. The EX stage trains the table with
// resolved control transfers. It also sends redirects when a prediction it
// carried down the pipe turns out to be wrong.
//
// Ports
//   CLK, nRST    clock, asynchronous active-low reset
//   stall        hold pc this cycle (hazard unit)
//   redirect     load redirect_pc this cycle; wins over stall
//   redirect_pc  corrected next PC from EX
//   upd_valid    EX resolved a control transfer this cycle (see below)
//   upd_pc       PC of the resolved instruction
//   upd_taken    resolved direction
//   upd_target   resolved target address
//   pc           current fetch PC
//   npc          predicted next PC for pc
//   pred_taken   npc came from the BTB
//   pred_hit     BTB tag hit on pc, regardless of counter state
//
// Update interface: upd_valid is a single-cycle, valid-only strobe. It has no
// ready; the BTB accepts it at every rising edge where nRST is high, and it
// is not affected by stall or redirect. Lookup and update use the same array.
// A lookup of an entry that is being written in the same cycle returns the
// old contents, and the new contents appear in the next cycle.
// -----------------------------------------------------------------------------
module pc_btb #(
  parameter int              WIDTH       = 32,
  parameter int              BTB_ENTRIES = 16,
  parameter logic [WIDTH-1:0] RESET_PC   = '0
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             stall,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             upd_valid,
  input  logic [WIDTH-1:0] upd_pc,
  input  logic             upd_taken,
  input  logic [WIDTH-1:0] upd_target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] npc,
  output logic             pred_taken,
  output logic             pred_hit
);

  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = WIDTH - IDX - 2;

  // Table storage, one element per entry
  logic             valid_q  [BTB_ENTRIES];
  logic [TAG_W-1:0] tag_q    [BTB_ENTRIES];
  logic [WIDTH-1:0] target_q [BTB_ENTRIES];
  logic [1:0]       ctr_q    [BTB_ENTRIES];

  // Lookup side
  logic [IDX-1:0]   look_idx;
  logic [TAG_W-1:0] look_tag;

  // Update side
  logic [IDX-1:0]   upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic [1:0]       upd_ctr;

  // Byte-offset bits of the update PC have no meaning for word-aligned
  // instructions.
  logic unused_upd_bits;
  assign unused_upd_bits = ^upd_pc[1:0];

  assign look_idx = pc[IDX+1:2];
  assign look_tag = pc[WIDTH-1:IDX+2];
  assign upd_idx  = upd_pc[IDX+1:2];
  assign upd_tag  = upd_pc[WIDTH-1:IDX+2];

  // Combinational prediction for the current pc. The add wraps modulo
  // 2^WIDTH, so the last word of the address space is followed by 0.
  always_comb begin
    pred_hit   = valid_q[look_idx] && (tag_q[look_idx] == look_tag);
    pred_taken = pred_hit && ctr_q[look_idx][1];
    npc        = pred_taken ? target_q[look_idx] : (pc + WIDTH'(4));
  end

  // Counter training for a tag hit. The counter saturates at 2'b00 and 2'b11.
  always_comb begin
    upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    upd_ctr = ctr_q[upd_idx];
    if (upd_taken) begin
      if (ctr_q[upd_idx] != 2'b11) upd_ctr = ctr_q[upd_idx] + 2'd1;
    end else begin
      if (ctr_q[upd_idx] != 2'b00) upd_ctr = ctr_q[upd_idx] - 2'd1;
    end
  end

  // PC register. redirect has priority over stall.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= redirect_pc;
    end else if (!stall) begin
      pc <= npc;
    end
  end

  // BTB array. A not-taken resolution that misses does not allocate, because
  // an entry that predicts fall-through gives nothing beyond pc+4. A taken
  // miss replaces whatever entry holds that index (direct-mapped). The new
  // entry starts weakly taken.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (upd_valid) begin
      if (upd_hit) begin
        ctr_q[upd_idx] <= upd_ctr;
        if (upd_taken) target_q[upd_idx] <= upd_target;
      end else if (upd_taken) begin
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target;
        ctr_q[upd_idx]    <= 2'b10;
      end
    end
  end

endmodule
